// File: rtl/led_sweep_sequencer_if.sv
// rtl/led_sweep_sequencer_if.sv - control inputs and display outputs of the LED sweep sequencer
interface led_sweep_sequencer_if;
  logic        Speed;
  logic        Mode;
  logic [3:0]  Pattern;
  logic [1:0]  Times;
  logic [15:0] LedOut;
  logic [2:0]  now_group;
  logic [1:0]  now_times;
  logic [3:0]  PatternReg;

  // Driver side: supplies the controls, observes the display state
  modport master (
    output Speed, Mode, Pattern, Times,
    input  LedOut, now_group, now_times, PatternReg
  );

  // Sequencer side
  modport slave (
    input  Speed, Mode, Pattern, Times,
    output LedOut, now_group, now_times, PatternReg
  );
endinterface

// File: rtl/led_sweep_sequencer.sv
// rtl/led_sweep_sequencer.sv - tick divider and 8-step bounce sweep of a 4-bit pattern over 16 LEDs
module led_sweep_sequencer #(
  parameter int DIV_FAST = 12_500_000,
  parameter int DIV_SLOW = 50_000_000,
  parameter int CNT_W    = 26
) (
  input  logic                 clk,
  input  logic                 reset,
  led_sweep_sequencer_if.slave bus
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state;
  logic [CNT_W-1:0]   div_cnt;
  logic               mode_q;

  logic [CNT_W-1:0]   lim;
  logic               tick;
  logic               start;
  logic [2:0]         g_next;

  // LED image for a step: the path 0,1,2,3,4,3,2,1 folds steps 5..7 back
  // onto 3..1; each position moves the nibble by 3 LEDs (max shift 12).
  function automatic logic [15:0] led_at(input logic [3:0] pat, input logic [2:0] g);
    logic [2:0] pos;
    logic [3:0] sh;
    pos = (g <= 3'd4) ? g : (3'd0 - g);
    sh  = {1'b0, pos} + {pos, 1'b0};
    return {12'b0, pat} << sh;
  endfunction

  // Tick limit follows Speed immediately; >= lets an overshot count fire at once
  always_comb begin
    lim    = bus.Speed ? CNT_W'(DIV_FAST) : CNT_W'(DIV_SLOW);
    tick   = (div_cnt >= (lim - CNT_W'(1)));
    start  = bus.Mode & ~mode_q;
    g_next = bus.now_group + 3'd1;
  end

  // Sequencer FSM with registered outputs; Mode=0 aborts from any state
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state          <= IDLE;
      div_cnt        <= '0;
      mode_q         <= 1'b0;
      bus.now_group  <= 3'd0;
      bus.now_times  <= 2'd0;
      bus.PatternReg <= 4'd0;
      bus.LedOut     <= 16'd0;
    end else begin
      mode_q <= bus.Mode;
      if (!bus.Mode) begin
        state         <= IDLE;
        div_cnt       <= '0;
        bus.now_group <= 3'd0;
        bus.now_times <= bus.Times;
        bus.LedOut    <= {4{bus.Pattern}};
      end else begin
        case (state)
          IDLE: begin
            div_cnt       <= '0;
            bus.now_group <= 3'd0;
            bus.now_times <= bus.Times;
            if (start) begin
              state          <= RUN;
              bus.PatternReg <= bus.Pattern;
              bus.LedOut     <= led_at(bus.Pattern, 3'd0);
            end else begin
              bus.LedOut     <= {4{bus.Pattern}};
            end
          end
          RUN: begin
            if (tick) begin
              div_cnt <= '0;
              if (bus.now_group == 3'd7 && bus.now_times == 2'd0) begin
                state         <= DONE;
                bus.now_group <= 3'd0;
                bus.LedOut    <= 16'd0;
              end else begin
                if (bus.now_group == 3'd7)
                  bus.now_times <= bus.now_times - 2'd1;
                bus.now_group <= g_next;
                bus.LedOut    <= led_at(bus.PatternReg, g_next);
              end
            end else begin
              div_cnt <= div_cnt + CNT_W'(1);
            end
          end
          DONE: begin
            div_cnt       <= '0;
            bus.now_group <= 3'd0;
            bus.LedOut    <= 16'd0;
          end
          default: begin
            state   <= IDLE;
            div_cnt <= '0;
          end
        endcase
      end
    end
  end

endmodule
